logic_op_stream: RTL and testbench

- Parametrised, registered bitwise-logic unit with valid/ready handshakes on input and output.
- Pairwise mode: one result per accepted operand pair.
- Accumulate mode: folds a burst of operands into one result using the selected op, with beat count and status flags.
- Sits between a stream producer and consumer in the datapath and supersedes the single-bit combinational selector.

---
 rtl/logic_op_stream_pkg.sv | 18 +
 rtl/logic_op_stream_if.sv | 30 +++
 rtl/logic_op_stream_unit.sv | 28 ++
 rtl/logic_op_stream.sv | 139 +++++++++++++
 tb/tb_logic_op_stream.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_op_stream_pkg.sv
// Shared op-code constants and FSM state type for the logic_op_stream datapath.
package logic_op_stream_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_op_stream_if.sv
// Operand/result stream bundle; slave is the logic unit side, master the producer/consumer side.
interface logic_op_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_mode;
    logic             in_last;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic [CNT_W-1:0] dout_cnt;
    logic             dout_zero;
    logic             dout_par;
    logic             busy;

    modport slave (
        input  in_valid, in_op, in_mode, in_last, din_a, din_b, out_ready,
        output in_ready, out_valid, dout, dout_cnt, dout_zero, dout_par, busy
    );

    modport master (
        output in_valid, in_op, in_mode, in_last, din_a, din_b, out_ready,
        input  in_ready, out_valid, dout, dout_cnt, dout_zero, dout_par, busy
    );
endinterface

// File: rtl/logic_op_stream_unit.sv
// Combinational bitwise function f(x,y) selected by a 3-bit op code.
module logic_op_unit
    import logic_op_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_XNOR: f = ~(x ^ y);
            OP_NAND: f = ~(x & y);
            OP_NOR:  f = ~(x | y);
            OP_ANDN: f = x & ~y;
            OP_PASS: f = x;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_stream.sv
// Registered bitwise-logic stream unit: pairwise results or burst accumulation with beat count and flags.
module logic_op_stream
    import logic_op_stream_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter int ACC_EN = 1
) (
    input logic               clk,
    input logic               rst,
    logic_op_stream_if.slave  bus
);

    state_e           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0]       op_q, op_n;
    logic [WIDTH-1:0] res, res_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             zero, zero_n;
    logic             par, par_n;
    logic             ovalid, ovalid_n;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH-1:0] fx, fy, fres;
    logic [2:0]       fop;

    assign bus.in_ready  = !ovalid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = ovalid;
    assign bus.dout      = res;
    assign bus.dout_cnt  = rcnt;
    assign bus.dout_zero = zero;
    assign bus.dout_par  = par;
    assign bus.busy      = (state == ST_ACC);

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // One shared function unit: in a burst it folds the running acc with din_a under the latched op.
    assign fx  = (state == ST_ACC) ? acc   : bus.din_a;
    assign fy  = (state == ST_ACC) ? bus.din_a : bus.din_b;
    assign fop = (state == ST_ACC) ? op_q  : bus.in_op;

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .x  (fx),
        .y  (fy),
        .op (fop),
        .f  (fres)
    );

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        op_n     = op_q;
        res_n    = res;
        rcnt_n   = rcnt;
        zero_n   = zero;
        par_n    = par;
        ovalid_n = ovalid;
        load     = 1'b0;
        load_val = '0;
        load_cnt = '0;

        if (ovalid && bus.out_ready)
            ovalid_n = 1'b0;

        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if ((ACC_EN != 0) && bus.in_mode) begin
                        if (bus.in_last) begin
                            load     = 1'b1;
                            load_val = bus.din_a;
                            load_cnt = CNT_W'(1);
                        end else begin
                            acc_n   = bus.din_a;
                            cnt_n   = CNT_W'(1);
                            op_n    = bus.in_op;
                            state_n = ST_ACC;
                        end
                    end else begin
                        load     = 1'b1;
                        load_val = fres;
                        load_cnt = CNT_W'(1);
                    end
                end
                ST_ACC: begin
                    if (bus.in_last) begin
                        load     = 1'b1;
                        load_val = fres;
                        load_cnt = cnt_inc;
                        state_n  = ST_IDLE;
                    end else begin
                        acc_n = fres;
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (load) begin
            res_n    = load_val;
            rcnt_n   = load_cnt;
            zero_n   = ~|load_val;
            par_n    = ^load_val;
            ovalid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            res    <= '0;
            rcnt   <= '0;
            zero   <= 1'b0;
            par    <= 1'b0;
            ovalid <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            res    <= res_n;
            rcnt   <= rcnt_n;
            zero   <= zero_n;
            par    <= par_n;
            ovalid <= ovalid_n;
        end
    end

endmodule

// File: tb/tb_logic_op_stream.sv
// Self-checking bench for logic_op_stream: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_logic_op_stream;
    import logic_op_stream_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_op_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();
    logic_op_stream_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

    logic_op_stream #(.WIDTH(8), .CNT_W(8), .ACC_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic_op_stream #(.WIDTH(8), .CNT_W(4), .ACC_EN(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        logic       z;
        logic       p;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [7:0] d, input logic [7:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        e.z = (d == 8'h00);
        e.p = ^d;
        return e;
    endfunction

    // Scoreboard: each consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'(bus.dout), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_dout", 32'(bus.dout), 32'(e.d));
                check("sb_cnt",  32'(bus.dout_cnt), 32'(e.c));
                check("sb_zero", 32'(bus.dout_zero), 32'(e.z));
                check("sb_par",  32'(bus.dout_par), 32'(e.p));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic mode, input logic last,
                        input logic [7:0] a, input logic [7:0] b);
        int n;
        bus.in_op    = op;
        bus.in_mode  = mode;
        bus.in_last  = last;
        bus.din_a    = a;
        bus.din_b    = b;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 32'(bus.in_ready), 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_AND,  8'hC3, 8'h5A, 8'h42};
        vecs[1]  = '{OP_OR,   8'hC3, 8'h5A, 8'hDB};
        vecs[2]  = '{OP_XOR,  8'hC3, 8'h5A, 8'h99};
        vecs[3]  = '{OP_XNOR, 8'hC3, 8'h5A, 8'h66};
        vecs[4]  = '{OP_NAND, 8'hC3, 8'h5A, 8'hBD};
        vecs[5]  = '{OP_NOR,  8'hC3, 8'h5A, 8'h24};
        vecs[6]  = '{OP_ANDN, 8'hC3, 8'h5A, 8'h81};
        vecs[7]  = '{OP_PASS, 8'hC3, 8'h5A, 8'hC3};
        vecs[8]  = '{OP_AND,  8'hAA, 8'h0F, 8'h0A};
        vecs[9]  = '{OP_XOR,  8'hFF, 8'hFF, 8'h00};
        vecs[10] = '{OP_ANDN, 8'hF0, 8'hFF, 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_op     = OP_AND;
        bus.in_mode   = 1'b0;
        bus.in_last   = 1'b0;
        bus.din_a     = '0;
        bus.din_b     = '0;
        bus.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_op     = OP_OR;
        bus4.in_mode   = 1'b1;
        bus4.in_last   = 1'b0;
        bus4.din_a     = '0;
        bus4.din_b     = '0;
        bus4.out_ready = 1'b1;

        // 1. Reset state, then asynchronous reset between edges
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_dout",      32'(bus.dout), 32'h0);
        check("rst_cnt",       32'(bus.dout_cnt), 32'h0);
        check("rst_busy",      32'(bus.busy), 32'h0);
        check("rst_in_ready",  32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        idle(1);
        bus.out_ready = 1'b0;
        send(OP_OR, 1'b0, 1'b0, 8'h01, 8'h02);
        check("pre_arst_valid", 32'(bus.out_valid), 32'h1);
        check("pre_arst_dout",  32'(bus.dout), 32'h03);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check("arst_dout",      32'(bus.dout), 32'h0);
        check("arst_cnt",       32'(bus.dout_cnt), 32'h0);
        check("arst_in_ready",  32'(bus.in_ready), 32'h1);
        check("arst_busy",      32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(1);

        // 2. Pairwise table, back-to-back with one-cycle latency
        for (int i = 0; i < 11; i++) begin
            sb.push_back(mk_exp(vecs[i].exp, 8'd1));
            send(vecs[i].op, 1'b0, 1'b0, vecs[i].a, vecs[i].b);
            check("pw_valid", 32'(bus.out_valid), 32'h1);
            check("pw_dout",  32'(bus.dout), 32'(vecs[i].exp));
        end
        idle(2);

        // 3. Backpressure: held result, blocked second beat
        bus.out_ready = 1'b0;
        sb.push_back(mk_exp(8'h0F, 8'd1));
        send(OP_AND, 1'b0, 1'b0, 8'hFF, 8'h0F);
        sb.push_back(mk_exp(8'h00, 8'd1));
        bus.in_op = OP_OR; bus.din_a = 8'h00; bus.din_b = 8'h00; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_dout_held", 32'(bus.dout), 32'h0F);
            check("bp_in_ready",  32'(bus.in_ready), 32'h0);
            check("bp_valid",     32'(bus.out_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second_dout", 32'(bus.dout), 32'h00);
        check("bp_second_zero", 32'(bus.dout_zero), 32'h1);
        check("bp_second_valid", 32'(bus.out_valid), 32'h1);
        idle(2);

        // 4. XOR burst, op/mode changed mid-burst, with an idle gap
        check("acc_busy_before", 32'(bus.busy), 32'h0);
        send(OP_XOR, 1'b1, 1'b0, 8'h01, 8'h77);
        check("acc_busy_b1", 32'(bus.busy), 32'h1);
        check("acc_no_out_b1", 32'(bus.out_valid), 32'h0);
        send(OP_AND, 1'b0, 1'b0, 8'h02, 8'h00);
        idle(1);
        check("acc_busy_gap", 32'(bus.busy), 32'h1);
        check("acc_no_out_gap", 32'(bus.out_valid), 32'h0);
        send(OP_OR, 1'b1, 1'b0, 8'h04, 8'h00);
        sb.push_back(mk_exp(8'h0F, 8'd4));
        send(OP_NAND, 1'b0, 1'b1, 8'h08, 8'h00);
        check("acc_busy_after", 32'(bus.busy), 32'h0);
        check("acc_dout", 32'(bus.dout), 32'h0F);
        check("acc_cnt",  32'(bus.dout_cnt), 32'h4);
        check("acc_par",  32'(bus.dout_par), 32'h0);
        idle(2);

        // 5. AND burst, then a single-beat burst
        send(OP_AND, 1'b1, 1'b0, 8'hFF, 8'h00);
        send(OP_AND, 1'b1, 1'b0, 8'hF0, 8'h00);
        sb.push_back(mk_exp(8'h30, 8'd3));
        send(OP_AND, 1'b1, 1'b1, 8'h3C, 8'h00);
        check("and_burst_dout", 32'(bus.dout), 32'h30);
        sb.push_back(mk_exp(8'h00, 8'd1));
        send(OP_OR, 1'b1, 1'b1, 8'h00, 8'hFF);
        check("single_dout", 32'(bus.dout), 32'h00);
        check("single_zero", 32'(bus.dout_zero), 32'h1);
        check("single_busy", 32'(bus.busy), 32'h0);
        idle(2);

        // 6a. Beat counter saturation on the narrow-counter instance
        for (int i = 0; i < 20; i++) begin
            logic [7:0] one;
            one = 8'h01;
            bus4.din_a    = one << (i % 8);
            bus4.in_last  = (i == 19);
            bus4.in_valid = 1'b1;
            @(negedge clk);
            if (!bus4.in_ready) check("sat_in_ready", 32'(bus4.in_ready), 32'h1);
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        check("sat_valid", 32'(bus4.out_valid), 32'h1);
        check("sat_dout",  32'(bus4.dout), 32'hFF);
        check("sat_cnt",   32'(bus4.dout_cnt), 32'hF);
        check("sat_busy",  32'(bus4.busy), 32'h0);

        // 6b. Reset mid-burst discards the burst
        send(OP_OR, 1'b1, 1'b0, 8'h11, 8'h00);
        send(OP_OR, 1'b1, 1'b0, 8'h22, 8'h00);
        check("mid_busy", 32'(bus.busy), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(bus.busy), 32'h0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        sb.push_back(mk_exp(8'h0A, 8'd1));
        send(OP_AND, 1'b0, 1'b0, 8'hAA, 8'h0F);
        check("post_rst_dout", 32'(bus.dout), 32'h0A);
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check("post_rst_cnt",  32'(bus.dout_cnt), 32'h1);
        idle(5);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
